// File: rtl/step_counter.sv
// Registered up/down step sequencer: accepts load/clear/inc/dec commands over valid/ready and
// applies one inc_dec step per cycle, with saturating or wrap-around arithmetic.

module inc_dec #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] in,
    input  logic         mode,
    output logic [N-1:0] out
);

    localparam logic [N-1:0] One = {{(N-1){1'b0}}, 1'b1};

    // mode 0 increments, mode 1 decrements; both wrap modulo 2^N
    assign out = mode ? (in - One) : (in + One);

endmodule

module step_counter #(
    parameter int unsigned N = 4,
    parameter int unsigned S = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [N-1:0] cmd_data,
    input  logic [S-1:0] cmd_steps,
    input  logic         wrap_en,
    output logic [N-1:0] value,
    output logic         busy,
    output logic         done,
    output logic         at_max,
    output logic         at_min,
    output logic         sat_hit
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [1:0] OpInc   = 2'b00;
    localparam logic [1:0] OpDec   = 2'b01;
    localparam logic [1:0] OpLoad  = 2'b10;
    localparam logic [1:0] OpClear = 2'b11;

    localparam logic [N-1:0] ValMax = {N{1'b1}};
    localparam logic [S-1:0] StepOne = {{(S-1){1'b0}}, 1'b1};

    logic [1:0]   state_q, state_d;
    logic [N-1:0] value_q, value_d;
    logic [S-1:0] remaining_q, remaining_d;
    logic         dir_q, dir_d;
    logic         wrap_q, wrap_d;
    logic         sat_hit_q, sat_hit_d;

    logic         accept;
    logic         blocked;
    logic [N-1:0] step_value;

    inc_dec #(
        .N (N)
    ) u_inc_dec (
        .in   (value_q),
        .mode (dir_q),
        .out  (step_value)
    );

    assign cmd_ready = (state_q == StIdle) && !rst;
    assign accept    = cmd_valid && cmd_ready;

    // In saturating mode a step that would cross a boundary is consumed but not applied
    assign blocked = !wrap_q && (dir_q ? (value_q == '0) : (value_q == ValMax));

    always_comb begin
        state_d     = state_q;
        value_d     = value_q;
        remaining_d = remaining_q;
        dir_d       = dir_q;
        wrap_d      = wrap_q;
        sat_hit_d   = sat_hit_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    sat_hit_d = 1'b0;
                    wrap_d    = wrap_en;
                    dir_d     = (cmd_op == OpDec);
                    case (cmd_op)
                        OpLoad: begin
                            value_d = cmd_data;
                            state_d = StDone;
                        end
                        OpClear: begin
                            value_d = '0;
                            state_d = StDone;
                        end
                        OpInc, OpDec: begin
                            remaining_d = cmd_steps;
                            state_d     = (cmd_steps == '0) ? StDone : StRun;
                        end
                        default: state_d = StIdle;
                    endcase
                end
            end
            StRun: begin
                if (blocked) begin
                    sat_hit_d = 1'b1;
                end else begin
                    value_d = step_value;
                end
                remaining_d = remaining_q - StepOne;
                if (remaining_q == StepOne) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            value_q     <= '0;
            remaining_q <= '0;
            dir_q       <= 1'b0;
            wrap_q      <= 1'b0;
            sat_hit_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            value_q     <= value_d;
            remaining_q <= remaining_d;
            dir_q       <= dir_d;
            wrap_q      <= wrap_d;
            sat_hit_q   <= sat_hit_d;
        end
    end

    assign value   = value_q;
    assign busy    = (state_q == StRun) || (state_q == StDone);
    assign done    = (state_q == StDone);
    assign at_max  = (value_q == ValMax);
    assign at_min  = (value_q == '0);
    assign sat_hit = sat_hit_q;

endmodule
